pwm_burst_array: RTL and testbench

//  N-channel PWM burst generator, successor to the fixed 6+1 channel PWM path.
//  - Period, high time, phase delay and pulse count are runtime-programmable per channel,

---
 rtl/pwm_burst_array.sv | 181 ++++++++++++++++++
 tb/tb_pwm_burst_array.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_burst_array.sv
// N-channel PWM burst generator with per-channel shadow/active configuration banks
// and group start/stop through a channel mask.
module pwm_burst_array #(
  parameter int NUM_CH = 6,
  parameter int CNT_W  = 16,
  parameter int CH_AW  = 5
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cfg_wr,
  input  logic [CH_AW-1:0]  cfg_ch,
  input  logic [1:0]        cfg_addr,
  input  logic [CNT_W-1:0]  cfg_wdata,
  input  logic [NUM_CH-1:0] trig_mask,
  input  logic              trig_start,
  input  logic              trig_stop,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] pwm_busy,
  output logic [NUM_CH-1:0] pwm_done,
  output logic [NUM_CH-1:0] cfg_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam logic [1:0] FLD_PERIOD = 2'd0;
  localparam logic [1:0] FLD_HIGH   = 2'd1;
  localparam logic [1:0] FLD_NPULSE = 2'd2;
  localparam logic [1:0] FLD_DELAY  = 2'd3;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] sh_period_q, sh_high_q, sh_npulse_q, sh_delay_q;
      logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
      logic [CNT_W-1:0] npulse_q, npulse_d, delay_q, delay_d;
      logic [CNT_W-1:0] cnt_q, cnt_d, dcnt_q, dcnt_d, pcnt_q, pcnt_d;
      logic [CNT_W:0]   cnt_inc_s;
      state_e           state_q, state_d;
      logic             out_q, out_d, busy_q, busy_d;
      logic             done_q, done_d, err_q, err_d;
      logic             wr_sel_s, start_s, stop_s, wrap_s;

      assign wr_sel_s  = cfg_wr && (cfg_ch == CH_AW'(gi));
      assign start_s   = trig_start && trig_mask[gi];
      assign stop_s    = trig_stop && trig_mask[gi];
      // Wrap on cnt+1 >= PERIOD so a degenerate PERIOD can never let cnt run away.
      assign cnt_inc_s = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
      assign wrap_s    = (cnt_inc_s >= {1'b0, period_q});

      // Shadow bank: written only by the configuration port.
      always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
          sh_period_q <= '0;
          sh_high_q   <= '0;
          sh_npulse_q <= '0;
          sh_delay_q  <= '0;
        end else if (wr_sel_s) begin
          case (cfg_addr)
            FLD_PERIOD: sh_period_q <= cfg_wdata;
            FLD_HIGH:   sh_high_q   <= cfg_wdata;
            FLD_NPULSE: sh_npulse_q <= cfg_wdata;
            FLD_DELAY:  sh_delay_q  <= cfg_wdata;
            default:    sh_period_q <= sh_period_q;
          endcase
        end else begin
          sh_period_q <= sh_period_q;
        end
      end

      // Channel FSM next state, active-bank updates and output decode.
      always_comb begin
        state_d  = state_q;
        period_d = period_q;
        high_d   = high_q;
        npulse_d = npulse_q;
        delay_d  = delay_q;
        cnt_d    = cnt_q;
        dcnt_d   = dcnt_q;
        pcnt_d   = pcnt_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
          ST_IDLE: begin
            period_d = sh_period_q;
            high_d   = sh_high_q;
            npulse_d = sh_npulse_q;
            delay_d  = sh_delay_q;
            cnt_d    = '0;
            dcnt_d   = '0;
            pcnt_d   = '0;
            if (start_s && !stop_s) begin
              if (sh_period_q < CNT_W'(2)) begin
                err_d = 1'b1;
              end else if (sh_delay_q != '0) begin
                state_d = ST_DELAY;
              end else begin
                state_d = ST_RUN;
              end
            end else begin
              state_d = ST_IDLE;
            end
          end
          ST_DELAY: begin
            if (stop_s) begin
              state_d = ST_IDLE;
            end else if (dcnt_q == delay_q - CNT_W'(1)) begin
              state_d = ST_RUN;
              cnt_d   = '0;
            end else begin
              dcnt_d = dcnt_q + CNT_W'(1);
            end
          end
          ST_RUN: begin
            if (stop_s) begin
              state_d = ST_IDLE;
            end else if (wrap_s) begin
              // Period boundary: PERIOD/HIGH follow the shadow bank from here on.
              cnt_d    = '0;
              period_d = sh_period_q;
              high_d   = sh_high_q;
              if ((npulse_q != '0) && (pcnt_q == npulse_q - CNT_W'(1))) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end else begin
                pcnt_d = pcnt_q + CNT_W'(1);
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
        busy_d = (state_d != ST_IDLE);
        out_d  = (state_d == ST_RUN) && (cnt_d < high_d);
      end

      // Channel state, active bank, counters and registered outputs.
      always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
          state_q  <= ST_IDLE;
          period_q <= '0;
          high_q   <= '0;
          npulse_q <= '0;
          delay_q  <= '0;
          cnt_q    <= '0;
          dcnt_q   <= '0;
          pcnt_q   <= '0;
          out_q    <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          err_q    <= 1'b0;
        end else begin
          state_q  <= state_d;
          period_q <= period_d;
          high_q   <= high_d;
          npulse_q <= npulse_d;
          delay_q  <= delay_d;
          cnt_q    <= cnt_d;
          dcnt_q   <= dcnt_d;
          pcnt_q   <= pcnt_d;
          out_q    <= out_d;
          busy_q   <= busy_d;
          done_q   <= done_d;
          err_q    <= err_d;
        end
      end

      assign pwm_out[gi]  = out_q;
      assign pwm_busy[gi] = busy_q;
      assign pwm_done[gi] = done_q;
      assign cfg_err[gi]  = err_q;
    end
  endgenerate

endmodule

// File: tb/tb_pwm_burst_array.sv
// Self-checking bench for pwm_burst_array: table of trigger vectors plus
// hand-written multi-cycle sequences, checked through an expectation queue.
module tb_pwm_burst_array;

  logic       sys_clk;
  logic       sys_rst;
  logic       cfg_wr;
  logic [4:0] cfg_ch;
  logic [1:0] cfg_addr;
  logic [15:0] cfg_wdata;
  logic [5:0] trig_mask;
  logic       trig_start;
  logic       trig_stop;
  logic [5:0] pwm_out;
  logic [5:0] pwm_busy;
  logic [5:0] pwm_done;
  logic [5:0] cfg_err;

  int n_checks;
  int n_errors;

  typedef struct {
    logic [5:0] out;
    logic [5:0] busy;
    logic [5:0] done;
    logic [5:0] err;
    int         tag;
  } exp_t;

  typedef struct {
    logic [5:0] mask;
    logic       start;
    logic       stop;
    logic [5:0] eo;
    logic [5:0] eb;
    logic [5:0] ee;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[8];

  pwm_burst_array #(.NUM_CH(6), .CNT_W(16), .CH_AW(5)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .cfg_wr    (cfg_wr),
    .cfg_ch    (cfg_ch),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .trig_mask (trig_mask),
    .trig_start(trig_start),
    .trig_stop (trig_stop),
    .pwm_out   (pwm_out),
    .pwm_busy  (pwm_busy),
    .pwm_done  (pwm_done),
    .cfg_err   (cfg_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Expected {out,busy,done} of one channel at cycle T+k after a start at T.
  function automatic logic [2:0] model(input int k, input int d, input int p,
                                       input int h, input int n);
    int r;
    int pi;
    int c;
    if (k <= 0) return 3'b000;
    if (k <= d) return 3'b010;
    r  = k - 1 - d;
    pi = r / p;
    c  = r % p;
    if (n != 0 && pi >= n) return (pi == n && c == 0) ? 3'b001 : 3'b000;
    return {(c < h) ? 1'b1 : 1'b0, 1'b1, 1'b0};
  endfunction

  function automatic logic [5:0] place(input logic b, input int ch);
    logic [5:0] v;
    v = '0;
    v[ch] = b;
    return v;
  endfunction

  task automatic cmp(input int tag, input string fld, input logic [5:0] got,
                     input logic [5:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL step%0d %s: got %b want %b", tag, fld, got, want);
    end
  endtask

  task automatic step(input int tag, input logic [5:0] eo, input logic [5:0] eb,
                      input logic [5:0] ed, input logic [5:0] ee);
    exp_t e;
    sb_q.push_back('{out: eo, busy: eb, done: ed, err: ee, tag: tag});
    @(posedge sys_clk);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL step%0d scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      cmp(e.tag, "pwm_out", pwm_out, e.out);
      cmp(e.tag, "pwm_busy", pwm_busy, e.busy);
      cmp(e.tag, "pwm_done", pwm_done, e.done);
      cmp(e.tag, "cfg_err", cfg_err, e.err);
    end
  endtask

  task automatic wr(input int ch, input int addr, input int data);
    cfg_wr    = 1'b1;
    cfg_ch    = 5'(ch);
    cfg_addr  = 2'(addr);
    cfg_wdata = 16'(data);
    @(posedge sys_clk);
    #1;
    cfg_wr = 1'b0;
  endtask

  task automatic cfg_ch_all(input int ch, input int p, input int h, input int n,
                            input int d);
    wr(ch, 0, p);
    wr(ch, 1, h);
    wr(ch, 2, n);
    wr(ch, 3, d);
  endtask

  initial begin
    logic [2:0] m;
    logic [5:0] eo;
    int c;
    n_checks   = 0;
    n_errors   = 0;
    sys_rst    = 1'b1;
    cfg_wr     = 1'b0;
    cfg_ch     = 5'd0;
    cfg_addr   = 2'd0;
    cfg_wdata  = 16'd0;
    trig_mask  = 6'd0;
    trig_start = 1'b0;
    trig_stop  = 1'b0;

    vecs[0] = '{mask: 6'b100001, start: 1'b1, stop: 1'b1, eo: 6'b000000, eb: 6'b000000, ee: 6'b000000};
    vecs[1] = '{mask: 6'b001000, start: 1'b1, stop: 1'b0, eo: 6'b000000, eb: 6'b000000, ee: 6'b001000};
    vecs[2] = '{mask: 6'b100001, start: 1'b1, stop: 1'b0, eo: 6'b100001, eb: 6'b100001, ee: 6'b000000};
    vecs[3] = '{mask: 6'b000010, start: 1'b1, stop: 1'b0, eo: 6'b000000, eb: 6'b000010, ee: 6'b000000};
    vecs[4] = '{mask: 6'b111111, start: 1'b1, stop: 1'b0, eo: 6'b110101, eb: 6'b110111, ee: 6'b001000};
    vecs[5] = '{mask: 6'b010000, start: 1'b0, stop: 1'b0, eo: 6'b000000, eb: 6'b000000, ee: 6'b000000};
    vecs[6] = '{mask: 6'b000000, start: 1'b1, stop: 1'b0, eo: 6'b000000, eb: 6'b000000, ee: 6'b000000};
    vecs[7] = '{mask: 6'b001000, start: 1'b1, stop: 1'b1, eo: 6'b000000, eb: 6'b000000, ee: 6'b000000};

    step(0, 6'd0, 6'd0, 6'd0, 6'd0);
    step(1, 6'd0, 6'd0, 6'd0, 6'd0);
    sys_rst = 1'b0;
    step(2, 6'd0, 6'd0, 6'd0, 6'd0);

    cfg_ch_all(0, 10, 3, 2, 0);
    cfg_ch_all(1, 4, 2, 0, 5);
    cfg_ch_all(2, 8, 4, 0, 0);
    cfg_ch_all(3, 1, 0, 0, 0);
    cfg_ch_all(4, 10, 12, 0, 0);
    cfg_ch_all(5, 5, 2, 1, 0);
    wr(6, 0, 3);
    step(3, 6'd0, 6'd0, 6'd0, 6'd0);

    // Trigger vectors, each followed by a stop of every channel.
    for (int i = 0; i < 8; i++) begin
      trig_mask  = vecs[i].mask;
      trig_start = vecs[i].start;
      trig_stop  = vecs[i].stop;
      step(100 + i, vecs[i].eo, vecs[i].eb, 6'd0, vecs[i].ee);
      trig_mask  = 6'b111111;
      trig_start = 1'b0;
      trig_stop  = 1'b1;
      step(200 + i, 6'd0, 6'd0, 6'd0, 6'd0);
      trig_stop  = 1'b0;
      trig_mask  = 6'd0;
    end

    // Ch0 finite burst of two pulses; a second start while busy is ignored.
    for (int k = 1; k <= 24; k++) begin
      trig_mask  = 6'b000001;
      trig_start = (k == 1 || k == 6);
      m = model(k, 0, 10, 3, 2);
      step(300 + k, place(m[2], 0), place(m[1], 0), place(m[0], 0), 6'd0);
    end
    trig_start = 1'b0;

    // Ch1 delayed continuous run, stopped by trig_stop.
    for (int k = 1; k <= 24; k++) begin
      trig_mask  = 6'b000010;
      trig_start = (k == 1);
      trig_stop  = (k == 21);
      m = (k <= 20) ? model(k, 5, 4, 2, 0) : 3'b000;
      step(400 + k, place(m[2], 1), place(m[1], 1), place(m[0], 1), 6'd0);
    end
    trig_stop = 1'b0;

    // Ch2 PERIOD shrink mid-period, then a HIGH write on a wrap cycle.
    for (int k = 1; k <= 30; k++) begin
      trig_mask  = 6'b000100;
      trig_start = (k == 1);
      cfg_wr     = (k == 4 || k == 15);
      cfg_ch     = 5'd2;
      cfg_addr   = (k == 4) ? 2'd0 : 2'd1;
      cfg_wdata  = (k == 4) ? 16'd6 : 16'd1;
      if (k <= 8) begin
        eo = place((k - 1) < 4, 2);
      end else if (k <= 20) begin
        c  = (k - 9) % 6;
        eo = place(c < 4, 2);
      end else begin
        c  = (k - 21) % 6;
        eo = place(c < 1, 2);
      end
      step(500 + k, eo, 6'b000100, 6'd0, 6'd0);
    end
    cfg_wr     = 1'b0;
    trig_start = 1'b0;
    trig_stop  = 1'b1;
    step(531, 6'd0, 6'd0, 6'd0, 6'd0);
    trig_stop  = 1'b0;

    // Ch4 HIGH above PERIOD stays high.
    for (int k = 1; k <= 25; k++) begin
      trig_mask  = 6'b010000;
      trig_start = (k == 1);
      m = model(k, 0, 10, 12, 0);
      step(600 + k, place(m[2], 4), place(m[1], 4), 6'd0, 6'd0);
    end
    trig_start = 1'b0;
    trig_stop  = 1'b1;
    step(626, 6'd0, 6'd0, 6'd0, 6'd0);
    trig_stop  = 1'b0;

    // Reset mid-burst clears outputs and configuration.
    trig_mask  = 6'b000001;
    trig_start = 1'b1;
    step(701, 6'b000001, 6'b000001, 6'd0, 6'd0);
    trig_start = 1'b0;
    step(702, 6'b000001, 6'b000001, 6'd0, 6'd0);
    sys_rst = 1'b1;
    step(703, 6'd0, 6'd0, 6'd0, 6'd0);
    sys_rst = 1'b0;
    step(704, 6'd0, 6'd0, 6'd0, 6'd0);
    trig_start = 1'b1;
    step(705, 6'd0, 6'd0, 6'd0, 6'b000001);
    trig_start = 1'b0;
    step(706, 6'd0, 6'd0, 6'd0, 6'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
